// File: rtl/impact_sram_wb_ctrl_if.sv
// Wishbone-classic bus bundle between the Caravel user-project bus and the SRAM controller.
interface impact_sram_wb_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/impact_sram_wb_ctrl.sv
// Wishbone slave driving port 0 of a 1024x32 dual-port SRAM macro; byte-lane writes
// are done as read-modify-write because the macro has no write mask.
module impact_sram_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  impact_sram_wb_ctrl_if.slave  wbs,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1
);

  localparam int unsigned TagLsb = ADDR_WIDTH + 2;
  localparam int unsigned Lanes  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StRd, StRdCap, StWr, StAck} state_e;

  state_e                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    csb0_q, csb0_d;
  logic                    web0_q, web0_d;
  logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0]   din0_q, din0_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [Lanes-1:0]        sel_q, sel_d;
  logic                    rmw_q, rmw_d;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    unused_adr;

  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  // Gating on ack_q blocks a second accept while the master is still dropping stb.
  assign hit = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q &&
               (wbs.wbs_adr_i[31:TagLsb] == BASE_ADDR[31:TagLsb]);

  always_comb begin
    merged = sram_dout0;
    for (int i = 0; i < int'(Lanes); i++) begin
      if (sel_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb0_d  = 1'b1;
    web0_d  = 1'b1;
    addr0_d = addr0_q;
    din0_d  = din0_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rmw_d   = rmw_q;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          if (!wbs.wbs_we_i) begin
            addr0_d = wbs.wbs_adr_i[TagLsb-1:2];
            csb0_d  = 1'b0;
            rmw_d   = 1'b0;
            state_d = StRd;
          end else if (wbs.wbs_sel_i == 4'hF) begin
            addr0_d = wbs.wbs_adr_i[TagLsb-1:2];
            csb0_d  = 1'b0;
            web0_d  = 1'b0;
            din0_d  = wbs.wbs_dat_i;
            state_d = StWr;
          end else if (wbs.wbs_sel_i != 4'h0) begin
            addr0_d = wbs.wbs_adr_i[TagLsb-1:2];
            csb0_d  = 1'b0;
            wdata_d = wbs.wbs_dat_i;
            sel_d   = wbs.wbs_sel_i;
            rmw_d   = 1'b1;
            state_d = StRd;
          end else begin
            state_d = StAck;
          end
        end
      end
      StRd: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        if (rmw_q) begin
          csb0_d  = 1'b0;
          web0_d  = 1'b0;
          din0_d  = merged;
          rmw_d   = 1'b0;
          state_d = StWr;
        end else begin
          dat_d   = sram_dout0;
          ack_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWr: begin
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      StAck: begin
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rmw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rmw_q   <= rmw_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign sram_csb0     = csb0_q;
  assign sram_web0     = web0_q;
  assign sram_addr0    = addr0_q;
  assign sram_din0     = din0_q;
  assign sram_csb1     = 1'b1;
  assign sram_addr1    = '0;

endmodule
